// File: rtl/tune_pkg.sv
// Shared constants and types for the front-panel tuning controller.
package tune_pkg;

   // Default datapath width, matches the nco phase accumulator.
   localparam int PHASE_W_DEF = 40;

   // Default button timing at 100 MHz.
   localparam int DEB_CYCLES_DEF    = 1000000;
   localparam int REPEAT_DELAY_DEF  = 50000000;
   localparam int REPEAT_PERIOD_DEF = 10000000;

   // Default preset bank depth.
   localparam int NUM_PRESETS_DEF = 4;

   // Step sizes: 100 Hz fine, 5 kHz coarse.
   localparam logic [39:0] FINE_STEP_DEF   = 40'h10c6f7;
   localparam logic [39:0] COARSE_STEP_DEF = 40'h346dc5d;

   // AM band window 500..1710 kHz, power-up at 936 kHz.
   localparam logic [39:0] MIN_INC_DEF   = 40'h147ae147b;
   localparam logic [39:0] MAX_INC_DEF   = 40'h460aa64c3;
   localparam logic [39:0] RESET_INC_DEF = 40'h2656abde3;

   // Bit positions of the step buttons in the step pulse vector.
   localparam int STEP_FINE_UP   = 0;
   localparam int STEP_FINE_DN   = 1;
   localparam int STEP_COARSE_UP = 2;
   localparam int STEP_COARSE_DN = 3;
   localparam int NUM_STEP_BTN   = 4;

   // Bit positions of the preset buttons in the preset pulse vector.
   localparam int PST_NEXT    = 0;
   localparam int PST_STORE   = 1;
   localparam int NUM_PST_BTN = 2;

   // Per-cycle action chosen by the arbiter, listed in priority order.
   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_STORE,
      ACT_NEXT,
      ACT_STEP_UP,
      ACT_STEP_DN
   } act_e;

endpackage

// File: rtl/btn_debounce.sv
// One front-panel button: 2-flop synchroniser, stability debouncer and
// optional auto-repeat, producing single-cycle registered pulses.
module btn_debounce #(
   parameter int DEB_CYCLES    = 1000000,
   parameter bit REPEAT_EN     = 1'b1,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic CLK,
   input  logic RST,
   input  logic btn_raw,
   output logic pulse
);

   localparam int DCW = $clog2(DEB_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RCW = $clog2(RMAX + 1);

   logic [1:0]     sync_q;
   logic [DCW-1:0] deb_cnt;
   logic           deb_q;
   logic           deb_d;
   logic [RCW-1:0] rep_cnt;
   logic           rep_on;
   logic           rise;
   logic           held;
   logic           rep_fire;

   // Two-stage synchroniser for the asynchronous raw input.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sync_q <= '0;
      else     sync_q <= {sync_q[0], btn_raw};
   end

   // Debounced level flips only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         deb_cnt <= '0;
         deb_q   <= 1'b0;
      end else if (sync_q[1] == deb_q) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DCW'(DEB_CYCLES - 1)) begin
         deb_cnt <= '0;
         deb_q   <= sync_q[1];
      end else begin
         deb_cnt <= deb_cnt + DCW'(1);
      end
   end

   // Delayed copy of the debounced level for edge detection.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) deb_d <= 1'b0;
      else     deb_d <= deb_q;
   end

   assign rise = deb_q & ~deb_d;
   assign held = deb_q & deb_d;

   // rep_cnt counts cycles since the last pulse; the first repeat waits
   // REPEAT_DELAY, later ones REPEAT_PERIOD.
   assign rep_fire = REPEAT_EN && held &&
                     (rep_on ? (rep_cnt == RCW'(REPEAT_PERIOD))
                             : (rep_cnt == RCW'(REPEAT_DELAY)));

   // Auto-repeat timer, cleared whenever the button is released.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rep_cnt <= '0;
         rep_on  <= 1'b0;
      end else if (!deb_q) begin
         rep_cnt <= '0;
         rep_on  <= 1'b0;
      end else if (rise) begin
         rep_cnt <= RCW'(1);
         rep_on  <= 1'b0;
      end else if (rep_fire) begin
         rep_cnt <= RCW'(1);
         rep_on  <= 1'b1;
      end else begin
         rep_cnt <= rep_cnt + RCW'(1);
      end
   end

   // Registered output pulse: press edge or repeat tick.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) pulse <= 1'b0;
      else     pulse <= rise | rep_fire;
   end

endmodule

// File: rtl/tune_ctrl.sv
// Front-panel tuning controller: debounced step/preset buttons drive a
// band-clamped nco phase increment and a small preset bank.
module tune_ctrl
   import tune_pkg::*;
#(
   parameter int                 PHASE_W       = PHASE_W_DEF,
   parameter int                 NUM_PRESETS   = NUM_PRESETS_DEF,
   parameter int                 DEB_CYCLES    = DEB_CYCLES_DEF,
   parameter int                 REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int                 REPEAT_PERIOD = REPEAT_PERIOD_DEF,
   parameter logic [PHASE_W-1:0] FINE_STEP     = FINE_STEP_DEF,
   parameter logic [PHASE_W-1:0] COARSE_STEP   = COARSE_STEP_DEF,
   parameter logic [PHASE_W-1:0] MIN_INC       = MIN_INC_DEF,
   parameter logic [PHASE_W-1:0] MAX_INC       = MAX_INC_DEF,
   parameter logic [PHASE_W-1:0] RESET_INC     = RESET_INC_DEF,
   localparam int                IDX_W         = $clog2(NUM_PRESETS)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               btn_fine_up,
   input  logic               btn_fine_dn,
   input  logic               btn_coarse_up,
   input  logic               btn_coarse_dn,
   input  logic               btn_preset_next,
   input  logic               btn_preset_store,
   output logic [PHASE_W-1:0] phase_inc,
   output logic               phase_upd,
   output logic [IDX_W-1:0]   preset_idx
);

   logic [NUM_STEP_BTN-1:0] step_raw;
   logic [NUM_STEP_BTN-1:0] step_pulse;
   logic [NUM_PST_BTN-1:0]  pst_raw;
   logic [NUM_PST_BTN-1:0]  pst_pulse;

   logic [NUM_PRESETS-1:0][PHASE_W-1:0] preset_q;

   act_e               act;
   logic [PHASE_W-1:0] step;
   logic [PHASE_W:0]   sum_ext;
   logic [PHASE_W:0]   dif_ext;
   logic [PHASE_W-1:0] up_val;
   logic [PHASE_W-1:0] dn_val;
   logic [IDX_W-1:0]   idx_nxt;

   assign step_raw[STEP_FINE_UP]   = btn_fine_up;
   assign step_raw[STEP_FINE_DN]   = btn_fine_dn;
   assign step_raw[STEP_COARSE_UP] = btn_coarse_up;
   assign step_raw[STEP_COARSE_DN] = btn_coarse_dn;
   assign pst_raw[PST_NEXT]        = btn_preset_next;
   assign pst_raw[PST_STORE]       = btn_preset_store;

   // Step buttons auto-repeat while held.
   for (genvar i = 0; i < NUM_STEP_BTN; i++) begin : g_step
      btn_debounce #(
         .DEB_CYCLES   (DEB_CYCLES),
         .REPEAT_EN    (1'b1),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_deb (
         .CLK    (CLK),
         .RST    (RST),
         .btn_raw(step_raw[i]),
         .pulse  (step_pulse[i])
      );
   end

   // Preset buttons act once per press.
   for (genvar i = 0; i < NUM_PST_BTN; i++) begin : g_pst
      btn_debounce #(
         .DEB_CYCLES   (DEB_CYCLES),
         .REPEAT_EN    (1'b0),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_deb (
         .CLK    (CLK),
         .RST    (RST),
         .btn_raw(pst_raw[i]),
         .pulse  (pst_pulse[i])
      );
   end

   // Arbitration: store beats next beats steps; coarse beats fine, and an
   // up/down cancel at one level falls through to the level below.
   always_comb begin
      act  = ACT_NONE;
      step = FINE_STEP;
      if (pst_pulse[PST_STORE]) begin
         act = ACT_STORE;
      end else if (pst_pulse[PST_NEXT]) begin
         act = ACT_NEXT;
      end else if (step_pulse[STEP_COARSE_UP] ^ step_pulse[STEP_COARSE_DN]) begin
         act  = step_pulse[STEP_COARSE_UP] ? ACT_STEP_UP : ACT_STEP_DN;
         step = COARSE_STEP;
      end else if (step_pulse[STEP_FINE_UP] ^ step_pulse[STEP_FINE_DN]) begin
         act = step_pulse[STEP_FINE_UP] ? ACT_STEP_UP : ACT_STEP_DN;
      end
   end

   // Saturating arithmetic with one guard bit; a set guard bit on the
   // difference means the subtraction wrapped below zero.
   always_comb begin
      sum_ext = {1'b0, phase_inc} + {1'b0, step};
      dif_ext = {1'b0, phase_inc} - {1'b0, step};
      up_val  = (sum_ext > {1'b0, MAX_INC}) ? MAX_INC : sum_ext[PHASE_W-1:0];
      dn_val  = (dif_ext[PHASE_W] || (dif_ext[PHASE_W-1:0] < MIN_INC))
                ? MIN_INC : dif_ext[PHASE_W-1:0];
      idx_nxt = preset_idx + IDX_W'(1);
   end

   // Preset bank: every slot powers up at the default station.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                   preset_q             <= {NUM_PRESETS{RESET_INC}};
      else if (act == ACT_STORE) preset_q[preset_idx] <= phase_inc;
   end

   // Output register; phase_upd marks only cycles where phase_inc is
   // rewritten (a recall always counts, a clamped no-op step does not).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         phase_inc  <= RESET_INC;
         phase_upd  <= 1'b0;
         preset_idx <= '0;
      end else begin
         phase_upd <= 1'b0;
         case (act)
            ACT_NEXT: begin
               preset_idx <= idx_nxt;
               phase_inc  <= preset_q[idx_nxt];
               phase_upd  <= 1'b1;
            end
            ACT_STEP_UP: begin
               if (up_val != phase_inc) begin
                  phase_inc <= up_val;
                  phase_upd <= 1'b1;
               end
            end
            ACT_STEP_DN: begin
               if (dn_val != phase_inc) begin
                  phase_inc <= dn_val;
                  phase_upd <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tune_ctrl.sv
// Self-checking bench for tune_ctrl with short debounce/repeat timing.
module tb_tune_ctrl;

   localparam int DEB = 4;
   localparam int DLY = 32;
   localparam int PER = 8;
   localparam int NP  = 4;

   localparam longint unsigned FINE   = 64'h10c6f7;
   localparam longint unsigned COARSE = 64'h346dc5d;
   localparam longint unsigned MINV   = 64'h147ae147b;
   localparam longint unsigned MAXV   = 64'h460aa64c3;
   localparam longint unsigned RSTV   = 64'h2656abde3;
   localparam longint unsigned FUP1   = 64'h2657b84da;

   // Button mask bits.
   localparam logic [5:0] M_FU = 6'b000001;
   localparam logic [5:0] M_FD = 6'b000010;
   localparam logic [5:0] M_CU = 6'b000100;
   localparam logic [5:0] M_CD = 6'b001000;
   localparam logic [5:0] M_NX = 6'b010000;
   localparam logic [5:0] M_ST = 6'b100000;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        btn_fine_up = 1'b0, btn_fine_dn = 1'b0;
   logic        btn_coarse_up = 1'b0, btn_coarse_dn = 1'b0;
   logic        btn_preset_next = 1'b0, btn_preset_store = 1'b0;
   logic [39:0] phase_inc;
   logic        phase_upd;
   logic [1:0]  preset_idx;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int upd_t[$];

   // Reference state.
   longint unsigned m_inc;
   int              m_idx;
   longint unsigned m_pre[NP];

   tune_ctrl #(
      .DEB_CYCLES   (DEB),
      .REPEAT_DELAY (DLY),
      .REPEAT_PERIOD(PER)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .btn_fine_up     (btn_fine_up),
      .btn_fine_dn     (btn_fine_dn),
      .btn_coarse_up   (btn_coarse_up),
      .btn_coarse_dn   (btn_coarse_dn),
      .btn_preset_next (btn_preset_next),
      .btn_preset_store(btn_preset_store),
      .phase_inc       (phase_inc),
      .phase_upd       (phase_upd),
      .preset_idx      (preset_idx)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Timestamp of every phase_upd pulse.
   always @(negedge CLK) if (phase_upd === 1'b1) upd_t.push_back(cyc);

   task automatic drive(input logic [5:0] m);
      btn_fine_up      = m[0];
      btn_fine_dn      = m[1];
      btn_coarse_up    = m[2];
      btn_coarse_dn    = m[3];
      btn_preset_next  = m[4];
      btn_preset_store = m[5];
   endtask

   task automatic model_reset();
      m_inc = RSTV;
      m_idx = 0;
      for (int i = 0; i < NP; i++) m_pre[i] = RSTV;
   endtask

   task automatic do_reset();
      drive(6'b0);
      @(posedge CLK); #1 RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
   endtask

   // Number of step events for a press held h cycles: one on press once
   // stable for DEB cycles, then repeats at DLY, DLY+PER, ... while held.
   function automatic int nsteps(input int h);
      if (h < DEB) return 0;
      if (h - 1 >= DLY) return 2 + (h - 1 - DLY) / PER;
      return 1;
   endfunction

   // Apply a press to the reference state; returns expected phase_upd count.
   task automatic model_press(input logic [5:0] m, input int h, output int exp_upd);
      int n;
      int dir;
      longint unsigned stp, nv;
      n = nsteps(h);
      exp_upd = 0;
      for (int e = 0; e < n; e++) begin
         if (m[5] && e == 0) begin
            m_pre[m_idx] = m_inc;
         end else if (m[4] && e == 0) begin
            m_idx = (m_idx + 1) % NP;
            m_inc = m_pre[m_idx];
            exp_upd++;
         end else begin
            dir = 0;
            stp = 0;
            if (m[2] != m[3])      begin dir = m[2] ? 1 : -1; stp = COARSE; end
            else if (m[0] != m[1]) begin dir = m[0] ? 1 : -1; stp = FINE;   end
            if (dir == 1)       nv = (m_inc + stp > MAXV) ? MAXV : m_inc + stp;
            else if (dir == -1) nv = (m_inc < MINV + stp) ? MINV : m_inc - stp;
            else                nv = m_inc;
            if (nv != m_inc) begin
               m_inc = nv;
               exp_upd++;
            end
         end
      end
   endtask

   // Hold the masked buttons for h cycles, then idle long enough to settle.
   task automatic press(input logic [5:0] m, input int h, output int t0);
      @(posedge CLK); #1;
      drive(m);
      t0 = cyc;
      repeat (h) @(posedge CLK);
      #1 drive(6'b0);
      repeat (12) @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      @(posedge CLK); #1;
      checks++;
      if (phase_inc !== RSTV[39:0] || preset_idx !== 2'd0 || phase_upd !== 1'b0) begin
         errors++;
         $display("FAIL reset_held: inc=%h idx=%0d upd=%b want inc=%h idx=0 upd=0",
                  phase_inc, preset_idx, phase_upd, RSTV[39:0]);
      end
      do_reset();
      checks++;
      if (phase_inc !== RSTV[39:0] || preset_idx !== 2'd0 || phase_upd !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: inc=%h idx=%0d upd=%b want inc=%h idx=0 upd=0",
                  phase_inc, preset_idx, phase_upd, RSTV[39:0]);
      end
   endtask

   task automatic test_fine_latency();
      int t0, base, eu, n;
      base = upd_t.size();
      press(M_FU, 10, t0);
      model_press(M_FU, 10, eu);
      n = upd_t.size() - base;
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL fine_count: got %0d pulses want 1", n);
      end
      checks++;
      if (n < 1 || upd_t[base] - t0 != 8) begin
         errors++;
         $display("FAIL fine_latency: got %0d want 8", (n < 1) ? -1 : upd_t[base] - t0);
      end
      checks++;
      if (phase_inc !== FUP1[39:0] || phase_inc !== m_inc[39:0]) begin
         errors++;
         $display("FAIL fine_value: got %h want %h", phase_inc, FUP1[39:0]);
      end
      // 3-cycle glitch must not pass the debouncer.
      base = upd_t.size();
      press(M_FU, 3, t0);
      model_press(M_FU, 3, eu);
      checks++;
      if (upd_t.size() != base || phase_inc !== FUP1[39:0]) begin
         errors++;
         $display("FAIL glitch: pulses=%0d inc=%h want 0 pulses inc=%h",
                  upd_t.size() - base, phase_inc, FUP1[39:0]);
      end
   endtask

   task automatic test_repeat();
      int t0, base, eu, n;
      int want[5] = '{8, 40, 48, 56, 64};
      longint unsigned start;
      start = m_inc;
      base = upd_t.size();
      press(M_CD, 60, t0);
      model_press(M_CD, 60, eu);
      n = upd_t.size() - base;
      checks++;
      if (n != 5 || eu != 5) begin
         errors++;
         $display("FAIL repeat_count: got %0d want 5", n);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= n || upd_t[base + i] - t0 != want[i]) begin
            errors++;
            $display("FAIL repeat_time[%0d]: got %0d want %0d", i,
                     (i >= n) ? -1 : upd_t[base + i] - t0, want[i]);
         end
      end
      checks++;
      if (phase_inc !== 40'(start - 5 * COARSE)) begin
         errors++;
         $display("FAIL repeat_value: got %h want %h", phase_inc, 40'(start - 5 * COARSE));
      end
   endtask

   task automatic test_cancel();
      int t0, base, eu;
      longint unsigned start;
      start = m_inc;
      base = upd_t.size();
      press(M_CU | M_CD, 10, t0);
      model_press(M_CU | M_CD, 10, eu);
      checks++;
      if (upd_t.size() != base || phase_inc !== start[39:0]) begin
         errors++;
         $display("FAIL cancel_coarse: pulses=%0d inc=%h want 0 pulses inc=%h",
                  upd_t.size() - base, phase_inc, start[39:0]);
      end
      base = upd_t.size();
      press(M_CU | M_FD, 10, t0);
      model_press(M_CU | M_FD, 10, eu);
      checks++;
      if (upd_t.size() - base != 1 || phase_inc !== 40'(start + COARSE)) begin
         errors++;
         $display("FAIL coarse_over_fine: pulses=%0d inc=%h want 1 pulse inc=%h",
                  upd_t.size() - base, phase_inc, 40'(start + COARSE));
      end
   endtask

   task automatic test_clamp();
      int t0, base, eu;
      press(M_CU, 1500, t0);
      model_press(M_CU, 1500, eu);
      checks++;
      if (phase_inc !== MAXV[39:0] || m_inc != MAXV) begin
         errors++;
         $display("FAIL clamp_max: got %h want %h", phase_inc, MAXV[39:0]);
      end
      base = upd_t.size();
      press(M_CU, 50, t0);
      press(M_FU, 10, t0);
      checks++;
      if (upd_t.size() != base || phase_inc !== MAXV[39:0]) begin
         errors++;
         $display("FAIL clamp_max_hold: pulses=%0d inc=%h want 0 pulses inc=%h",
                  upd_t.size() - base, phase_inc, MAXV[39:0]);
      end
      press(M_CD, 2200, t0);
      model_press(M_CD, 2200, eu);
      checks++;
      if (phase_inc !== MINV[39:0] || m_inc != MINV) begin
         errors++;
         $display("FAIL clamp_min: got %h want %h", phase_inc, MINV[39:0]);
      end
      base = upd_t.size();
      press(M_CD, 50, t0);
      press(M_FD, 10, t0);
      checks++;
      if (upd_t.size() != base || phase_inc !== MINV[39:0]) begin
         errors++;
         $display("FAIL clamp_min_hold: pulses=%0d inc=%h want 0 pulses inc=%h",
                  upd_t.size() - base, phase_inc, MINV[39:0]);
      end
   endtask

   task automatic test_presets();
      int t0, base, eu;
      longint unsigned want_inc[4];
      longint unsigned v2;
      do_reset();
      press(M_FU, 10, t0);
      model_press(M_FU, 10, eu);
      base = upd_t.size();
      press(M_ST, 10, t0);
      model_press(M_ST, 10, eu);
      checks++;
      if (upd_t.size() != base || phase_inc !== FUP1[39:0] || preset_idx !== 2'd0) begin
         errors++;
         $display("FAIL store: pulses=%0d inc=%h idx=%0d want 0 pulses inc=%h idx=0",
                  upd_t.size() - base, phase_inc, preset_idx, FUP1[39:0]);
      end
      want_inc = '{RSTV, RSTV, RSTV, FUP1};
      for (int i = 0; i < 4; i++) begin
         base = upd_t.size();
         press(M_NX, 10, t0);
         model_press(M_NX, 10, eu);
         checks++;
         if (upd_t.size() - base != 1 || preset_idx !== 2'((i + 1) % 4) ||
             phase_inc !== want_inc[i][39:0]) begin
            errors++;
            $display("FAIL next[%0d]: pulses=%0d idx=%0d inc=%h want 1 pulse idx=%0d inc=%h",
                     i, upd_t.size() - base, preset_idx, phase_inc, (i + 1) % 4,
                     want_inc[i][39:0]);
         end
      end
      // Store and next together: only the store lands.
      press(M_FU, 10, t0);
      model_press(M_FU, 10, eu);
      v2 = FUP1 + FINE;
      base = upd_t.size();
      press(M_ST | M_NX, 10, t0);
      model_press(M_ST | M_NX, 10, eu);
      checks++;
      if (upd_t.size() != base || preset_idx !== 2'd0 || phase_inc !== v2[39:0]) begin
         errors++;
         $display("FAIL store_next: pulses=%0d idx=%0d inc=%h want 0 pulses idx=0 inc=%h",
                  upd_t.size() - base, preset_idx, phase_inc, v2[39:0]);
      end
      for (int i = 0; i < 4; i++) begin
         press(M_NX, 10, t0);
         model_press(M_NX, 10, eu);
      end
      checks++;
      if (preset_idx !== 2'd0 || phase_inc !== v2[39:0]) begin
         errors++;
         $display("FAIL store_next_recall: idx=%0d inc=%h want idx=0 inc=%h",
                  preset_idx, phase_inc, v2[39:0]);
      end
   endtask

   task automatic test_reset_mid();
      int t0, base, eu;
      // Put a distinct value in slot 1 so a surviving preset would show.
      press(M_NX, 10, t0);
      press(M_CU, 10, t0);
      press(M_ST, 10, t0);
      @(posedge CLK); #1;
      drive(M_CU);
      repeat (40) @(posedge CLK);
      #1 RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (phase_inc !== RSTV[39:0] || preset_idx !== 2'd0 || phase_upd !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: inc=%h idx=%0d upd=%b want inc=%h idx=0 upd=0",
                  phase_inc, preset_idx, phase_upd, RSTV[39:0]);
      end
      drive(6'b0);
      RST = 1'b0;
      model_reset();
      base = upd_t.size();
      repeat (20) @(posedge CLK);
      #1;
      press(M_NX, 10, t0);
      model_press(M_NX, 10, eu);
      checks++;
      if (upd_t.size() - base != 1 || preset_idx !== 2'd1 || phase_inc !== RSTV[39:0]) begin
         errors++;
         $display("FAIL presets_lost: pulses=%0d idx=%0d inc=%h want 1 pulse idx=1 inc=%h",
                  upd_t.size() - base, preset_idx, phase_inc, RSTV[39:0]);
      end
   endtask

   task automatic test_random();
      int t0, base, eu, h, n;
      logic [5:0] m;
      logic [5:0] masks[12] = '{M_FU, M_FD, M_CU, M_CD, M_NX, M_ST, M_CU | M_CD,
                                M_FU | M_FD, M_CU | M_FD, M_FD | M_CD, M_ST | M_NX,
                                M_NX | M_FU};
      do_reset();
      for (int k = 0; k < 30; k++) begin
         m = masks[$urandom_range(0, 11)];
         h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 70))
                                         : int'($urandom_range(1, 12));
         base = upd_t.size();
         press(m, h, t0);
         model_press(m, h, eu);
         n = upd_t.size() - base;
         checks++;
         if (phase_inc !== m_inc[39:0] || preset_idx !== 2'(m_idx) || n != eu) begin
            errors++;
            $display("FAIL random[%0d] mask=%b h=%0d: inc=%h idx=%0d pulses=%0d want inc=%h idx=%0d pulses=%0d",
                     k, m, h, phase_inc, preset_idx, n, m_inc[39:0], m_idx, eu);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fine_latency();
      test_repeat();
      test_cancel();
      test_clamp();
      test_presets();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tune_ctrl.md
# tune_ctrl

Parametrised front-panel tuning controller for the AM receiver. It synchronises, debounces and auto-repeats the raw tuning buttons. It applies fine and coarse steps to the NCO phase increment with saturating clamping to a band window, and holds a small bank of storable station presets. It sits between the board buttons and the `nco` phase-increment input, all in the 100 MHz DSP clock domain.

## Interface
Parameters:
- `PHASE_W`, 40: phase increment width (matches `nco`).
- `NUM_PRESETS`, 4: preset slots; power of two, 2..16.
- `DEB_CYCLES`, 1000000: cycles a synchronised button must be stable before its debounced state changes.
- `REPEAT_DELAY`, 50000000: held cycles before auto-repeat starts.
- `REPEAT_PERIOD`, 10000000: cycles between auto-repeat steps.
- `FINE_STEP`, 40'h10c6f7: 100 Hz at 100 MHz.
- `COARSE_STEP`, 40'h346dc5d: 5 kHz.
- `MIN_INC`, 40'h147ae147b: 500 kHz.
- `MAX_INC`, 40'h460aa64c3: 1710 kHz.
- `RESET_INC`, 40'h2656abde3: 936 kHz.

Ports:
- `CLK` in 1: 100 MHz DSP clock.
- `RST` in 1: asynchronous, active-high reset.
- `btn_fine_up`, `btn_fine_dn`, `btn_coarse_up`, `btn_coarse_dn` in 1 each: raw, asynchronous, active-high.
- `btn_preset_next`, `btn_preset_store` in 1 each: raw, active-high.
- `phase_inc` out `PHASE_W`: current phase increment to `nco`.
- `phase_upd` out 1: one-cycle pulse, high in the cycle `phase_inc` takes a new value.
- `preset_idx` out `$clog2(NUM_PRESETS)`: active preset slot.

## Operation
- Every button passes through a 2-flop synchroniser and then a debouncer. The debounced state flips only after `DEB_CYCLES` consecutive cycles of a synchronised level differing from it. The counter clears on any sample that equals the current debounced state.
- Step buttons produce a step pulse on the debounced rising edge. While held, after `REPEAT_DELAY` cycles they produce further pulses every `REPEAT_PERIOD` cycles. The repeat counter clears on release.
- Preset buttons produce a rising-edge pulse only, with no repeat.
- Per-cycle step arbitration:
  - Any active coarse pulse overrides fine.
  - Up and down at the same level in the same cycle cancel, giving no step and no `phase_upd`.
  - A coarse cancel falls through to fine.
- Arithmetic is done in `PHASE_W+1` bits:
  - up: result = min(`phase_inc`+step, `MAX_INC`).
  - down: result = max(`phase_inc`−step, `MIN_INC`), with underflow detected via the extra bit.
  - A step that leaves the value unchanged (already at the limit) does not pulse `phase_upd`.
- Presets: a register bank of `NUM_PRESETS` × `PHASE_W`, every slot reset to `RESET_INC`.
  - store: writes `phase_inc` into slot `preset_idx`. `phase_inc` and `phase_upd` are unchanged.
  - next: `preset_idx` ← (`preset_idx`+1) mod `NUM_PRESETS`, and `phase_inc` ← the new slot contents. `phase_upd` pulses even if the value is equal.
- Priority within one cycle: store > next > step. Lower-priority pulses in that cycle are discarded, not queued.
- Out-of-window preset contents cannot occur, because stored values are always clamped.

## Timing
- Reset values:
  - `phase_inc`=`RESET_INC`, `phase_upd`=0, `preset_idx`=0.
  - All debounce and repeat counters 0; debounced states 0; synchronisers 0.
- Latency from a raw press, held stable, to the `phase_inc` update is 2 (sync) + `DEB_CYCLES` + 1 (edge/step register) + 1 (output register) cycles. `phase_upd` coincides with the new value.
- Auto-repeat step n≥1 occurs `REPEAT_DELAY` + (n−1)·`REPEAT_PERIOD` cycles after the first step.
- Throughput: at most one change to `phase_inc` per cycle.
- `RST` asserted mid-debounce or mid-repeat returns all state to reset values at once. Presets are lost.
- Bounce shorter than `DEB_CYCLES` generates no pulse.

## Structure
- Package `tune_pkg`: default `PHASE_W`, step constants, band-limit constants, and the arbitration-priority enum (`ACT_NONE`, `ACT_STORE`, `ACT_NEXT`, `ACT_STEP_UP`, `ACT_STEP_DN`).
- Sub-module `btn_debounce`: synchroniser, debouncer and optional repeat, with parameters `DEB_CYCLES`, `REPEAT_EN`, `REPEAT_DELAY` and `REPEAT_PERIOD`. It is instantiated six times, with repeat disabled for the preset buttons.
- The top of `tune_ctrl` holds arbitration, saturating arithmetic and the preset bank.

## Test plan
The bench uses `DEB_CYCLES`=4, `REPEAT_DELAY`=32 and `REPEAT_PERIOD`=8, with other parameters at their defaults.
- After reset: `phase_inc`=`0x2656abde3`, `preset_idx`=0, `phase_upd`=0.
- Press `btn_fine_up` for 10 cycles: exactly one `phase_upd`, `phase_inc`=`0x2657b84da`, 8 cycles after the press (2+4+1+1). A 3-cycle glitch gives no change.
- Hold `btn_coarse_dn` for 60 cycles: steps at t, t+32, t+40, t+48, t+56, giving 5 pulses and `phase_inc` decreasing by 5×`0x346dc5d`.
- Press `btn_coarse_up` and `btn_coarse_dn` together: no change. Press coarse up with fine down: one coarse up step.
- Clamp: hold up repeatedly from `RESET_INC` until `phase_inc`=`0x460aa64c3`. Further presses must not change it or pulse `phase_upd`. Mirror the check at `MIN_INC`.
- Presets: fine-up once, store, next, next, next, next. This gives `preset_idx` 1,2,3,0 and `phase_inc` `0x2656abde3` ×3 then `0x2657b84da`. Store and next in the same cycle: only the store takes effect.
